// File: rtl/beat_gen.sv
// beat_gen: beat (W) and phase (T) timing generator for the hardwired instruction controller.
module beat_gen #(
  parameter int TPH = 1
) (
  input  logic       MF,
  input  logic       CLR,
  input  logic       QD,
  input  logic       DP,
  input  logic       TJ,
  input  logic       SHORT,
  input  logic       LONG,
  input  logic       STOP,
  output logic [3:1] W,
  output logic [3:1] T,
  output logic       RUN
);
  typedef enum logic {ST_HALT, ST_RUN} state_t;
  localparam logic [3:0] LAST = 4'(TPH - 1);
  state_t     r_state, w_state;
  logic [2:0] r_pb, r_w, r_t, w_pb, w_w, w_t, w_nb;
  logic [3:0] r_cnt, w_cnt;
  logic       r_q1, r_q2, r_q3;
  logic       w_rise, w_last;
  assign w_rise = r_q2 & ~r_q3;
  assign w_last = r_cnt == LAST;
  assign w_nb   = r_w[0] ? (SHORT ? 3'b001 : 3'b010) : r_w[1] ? (LONG ? 3'b100 : 3'b001) : 3'b001;
  always_comb begin
    w_state = r_state;
    w_pb    = r_pb;
    w_w     = r_w;
    w_t     = r_t;
    w_cnt   = r_cnt;
    if (r_state == ST_HALT) begin
      if (w_rise && !TJ) begin
        w_state = ST_RUN;
        w_w     = r_pb;
        w_t     = 3'b001;
        w_cnt   = '0;
      end
    end else if (!w_last) begin
      w_cnt = r_cnt + 4'd1;
    end else begin
      w_cnt = '0;
      if (!r_t[2]) begin
        w_t = r_t << 1;
      end else if (STOP || DP || TJ) begin
        w_state = ST_HALT;
        w_pb    = w_nb;
        w_w     = '0;
        w_t     = '0;
      end else begin
        w_w = w_nb;
        w_t = 3'b001;
      end
    end
  end
  // q* reset high so a QD held through reset is not seen as a press
  always_ff @(posedge MF or negedge CLR) begin
    if (!CLR) begin
      r_state <= ST_HALT;
      r_pb    <= 3'b001;
      r_w     <= '0;
      r_t     <= '0;
      r_cnt   <= '0;
      r_q1    <= 1'b1;
      r_q2    <= 1'b1;
      r_q3    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_pb    <= w_pb;
      r_w     <= w_w;
      r_t     <= w_t;
      r_cnt   <= w_cnt;
      r_q1    <= QD;
      r_q2    <= r_q1;
      r_q3    <= r_q2;
    end
  end
  assign W   = r_w;
  assign T   = r_t;
  assign RUN = r_state == ST_RUN;
endmodule

// File: tb/tb_beat_gen.sv
// tb_beat_gen: directed checks of beat_gen at TPH=1 and TPH=4.
module tb_beat_gen;
  logic       MF = 1'b0, CLR = 1'b1, QD = 1'b1, DP = 1'b0, TJ = 1'b0;
  logic       SHORT = 1'b0, LONG = 1'b0, STOP = 1'b0;
  logic [3:1] W, T, W4, T4;
  logic       RUN, RUN4;
  int         n_checks = 0, n_fail = 0;

  beat_gen #(.TPH(1)) u_dut (
    .MF(MF), .CLR(CLR), .QD(QD), .DP(DP), .TJ(TJ),
    .SHORT(SHORT), .LONG(LONG), .STOP(STOP), .W(W), .T(T), .RUN(RUN)
  );
  beat_gen #(.TPH(4)) u_dut4 (
    .MF(MF), .CLR(CLR), .QD(QD), .DP(DP), .TJ(TJ),
    .SHORT(SHORT), .LONG(LONG), .STOP(STOP), .W(W4), .T(T4), .RUN(RUN4)
  );

  always #5 MF = ~MF;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge MF);
    #1;
  endtask

  // one-cycle QD pulse; returns just after the edge where T1 appears
  task automatic press();
    QD = 1'b1;
    step(1);
    QD = 1'b0;
    step(2);
  endtask

  task automatic check_out(input string tag, input logic [2:0] w, input logic [2:0] t, input logic r);
    check({tag, ".W"}, 8'(W), 8'(w));
    check({tag, ".T"}, 8'(T), 8'(t));
    check({tag, ".RUN"}, 8'(RUN), 8'(r));
  endtask

  initial begin
    #2 CLR = 1'b0;
    #2 check_out("reset", 3'b000, 3'b000, 1'b0);
    step(1);
    CLR = 1'b1;
    step(4);
    check_out("qd_held", 3'b000, 3'b000, 1'b0);
    QD = 1'b0;
    step(3);
    press();
    check_out("start", 3'b001, 3'b001, 1'b1);
    check("start4.W", 8'(W4), 8'b001);
    check("start4.T", 8'(T4), 8'b001);
    for (int i = 1; i <= 12; i++) begin
      step(1);
      check($sformatf("norm%0d.T", i), 8'(T), 8'(3'b001 << (i % 3)));
      check($sformatf("norm%0d.W", i), 8'(W), ((i / 3) % 2) ? 8'b010 : 8'b001);
      check($sformatf("tph4_%0d.T", i), 8'(T4), 8'(3'b001 << ((i / 4) % 3)));
      check($sformatf("tph4_%0d.W", i), 8'(W4), ((i / 12) % 2) ? 8'b010 : 8'b001);
    end
    step(4);
    check_out("w2t2", 3'b010, 3'b010, 1'b1);
    LONG = 1'b1;
    step(2);
    check_out("long_w3", 3'b100, 3'b001, 1'b1);
    LONG = 1'b0;
    step(3);
    check_out("w3_to_w1", 3'b001, 3'b001, 1'b1);
    SHORT = 1'b1;
    step(3);
    check_out("short_w1", 3'b001, 3'b001, 1'b1);
    LONG = 1'b1;
    step(3);
    check_out("short_long_w1", 3'b001, 3'b001, 1'b1);
    SHORT = 1'b0;
    LONG = 1'b0;
    step(3);
    check_out("after_short", 3'b010, 3'b001, 1'b1);
    LONG = 1'b1;
    STOP = 1'b1;
    step(1);
    check_out("stop_midbeat", 3'b010, 3'b010, 1'b1);
    step(2);
    check_out("stop_halt", 3'b000, 3'b000, 1'b0);
    STOP = 1'b0;
    LONG = 1'b0;
    step(2);
    check_out("stop_idle", 3'b000, 3'b000, 1'b0);
    press();
    check_out("resume_w3", 3'b100, 3'b001, 1'b1);
    step(3);
    check_out("resume_w1", 3'b001, 3'b001, 1'b1);
    STOP = 1'b1;
    step(1);
    STOP = 1'b0;
    step(2);
    check_out("stop_pulse", 3'b010, 3'b001, 1'b1);
    DP = 1'b1;
    step(3);
    check_out("dp_halt1", 3'b000, 3'b000, 1'b0);
    press();
    check_out("dp_step1", 3'b001, 3'b001, 1'b1);
    step(3);
    check_out("dp_halt2", 3'b000, 3'b000, 1'b0);
    press();
    check_out("dp_step2", 3'b010, 3'b001, 1'b1);
    step(3);
    check_out("dp_halt3", 3'b000, 3'b000, 1'b0);
    DP = 1'b0;
    TJ = 1'b1;
    press();
    step(1);
    check_out("tj_ignore", 3'b000, 3'b000, 1'b0);
    TJ = 1'b0;
    press();
    check_out("tj_resume", 3'b001, 3'b001, 1'b1);
    step(4);
    check_out("pre_clr", 3'b010, 3'b010, 1'b1);
    #2 CLR = 1'b0;
    #1 check_out("async_clr", 3'b000, 3'b000, 1'b0);
    #1 CLR = 1'b1;
    step(3);
    check_out("post_clr", 3'b000, 3'b000, 1'b0);
    press();
    check_out("restart_w1", 3'b001, 3'b001, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/beat_gen.md
# beat_gen

Beat and phase timing generator for the hardwired instruction controller. Produces the one-hot beat signals W[3:1] and phase signals T[3:1] that the controller decodes. Honors the controller's SHORT, LONG and STOP requests, plus the front-panel start (QD), single-step (DP) and debug-halt (TJ) controls. Sits between the panel/clock source and the controller; the controller's ST0 flop keeps updating on the falling edge of T3, which this block generates.

## Interface
- TPH, 1: MF cycles per T phase. Legal range 1..15.
- MF  input  1  master clock; all state changes on the rising edge.
- CLR  input  1  reset, asynchronous, active-low.
- QD  input  1  panel start button; asynchronous, level.
- DP  input  1  single-beat mode; sampled at end of beat.
- TJ  input  1  debug halt; sampled at end of beat.
- SHORT  input  1  from controller: end the instruction after W1.
- LONG  input  1  from controller: extend the instruction to W3.
- STOP  input  1  from controller: halt after the current beat.
- W  output  [3:1]  one-hot beat; 000 while halted.
- T  output  [3:1]  one-hot phase within a beat; 000 while halted.
- RUN  output  1  1 while a beat is executing.

## Operation
- States: HALT, RUN. Registers: pending beat PB (one-hot W1/W2/W3), current beat, current phase, phase counter (4 bits), QD synchronizer q1/q2/q3.
- Reset (CLR=0, async):
  - W=000, T=000, RUN=0.
  - State HALT, PB=W1, phase counter 0.
  - q1=q2=q3=1. A QD held high through reset therefore does not start the machine; it must be released and pressed again.
- QD start: q1<=QD, q2<=q1, q3<=q2. rise = q2 & ~q3.
  - In HALT with rise=1 and TJ=0, the next edge enters RUN with W=PB and T=T1.
  - rise is ignored in RUN.
  - rise is ignored while TJ=1.
- Phases: each phase lasts TPH MF cycles. Order is T1, T2, T3, then the end of the beat.
- End-of-beat decision: taken on the edge that ends the last cycle of T3, using the current beat and inputs sampled on that edge.
  - Next beat from W1: W1 if SHORT=1, else W2. LONG is ignored in W1, and SHORT has priority.
  - Next beat from W2: W3 if LONG=1, else W1. SHORT is ignored in W2.
  - Next beat from W3: always W1.
  - Halt condition: STOP | DP | TJ.
    - If 1: PB <= next beat, go to HALT, W=T=000, RUN=0.
    - Else: go straight to the next beat's T1 with no gap cycle.
- Halt is only ever taken at a beat boundary. A STOP/DP/TJ that pulses during T1/T2 and drops before the T3 end edge has no effect.
- Resume continues with PB, so the instruction sequence is preserved across halts. Example: a halt after W2 with LONG=1 resumes at W3.

## Timing
- QD rise to T1: QD high before edge k, then T1/W visible after edge k+2 (2-cycle sync plus edge detect). QD must be high for at least 1 MF cycle.
- Beat length: 3*TPH cycles.
- Instruction length at TPH=1:
  - SHORT: 3 cycles.
  - Normal: 6 cycles.
  - LONG: 9 cycles.
- W changes only on the same edge where T3 goes to T1. W is stable for the whole beat, so the controller's combinational decode sees no mid-beat glitch from W.
- T3's falling edge coincides with the beat-boundary edge, so the controller's ST0 update and this block's beat advance happen on the same MF edge.
- CLR asserted mid-beat clears all outputs immediately, without waiting for a clock.
- CLR released: the first possible T1 is 3 edges after a fresh QD rise.

## Test plan
- Reset and start: CLR=0 with QD=1 → W=000, T=000, RUN=0. Release CLR with QD still high → stays halted. Drop QD, then raise it at edge k → W=001, T=001 after edge k+2.
- Normal run, TPH=1, SHORT=LONG=STOP=0 → W sequence 001,010,001,010…, each held 3 cycles. T sequence 001,010,100 repeating.
- LONG asserted during W2 T3 → W3 follows, then W1. SHORT asserted in W1 → W1 repeats with no W2. SHORT=LONG=1 in W1 → W1 repeats.
- STOP=1 in W2 with LONG=1 → after W2 T3, W=000 and RUN=0. The next QD press resumes at W=100.
- DP=1, TJ=0 → one beat per QD press. TJ=1 → QD presses ignored; TJ=0 then QD → resumes. TPH=4 → each T phase lasts 4 cycles.
- CLR pulsed low during W2 T2 → outputs go to 000 asynchronously. After restart, the first beat is W1.
